// File: rtl/multiplier_iterative_param_if.sv
// Start/result handshake bundle for multiplier_iterative_param.
// The master drives requests and the slave returns products.
interface multiplier_iterative_param_if #(
    parameter int WIDTH = 32
);
    logic                 valid_in;
    logic                 ready_out;
    logic                 signed_in;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 valid_out;
    logic [2*WIDTH-1:0]   r;

    modport master (
        output valid_in, signed_in, a, b,
        input  ready_out, valid_out, r
    );

    modport slave (
        input  valid_in, signed_in, a, b,
        output ready_out, valid_out, r
    );
endinterface

// File: rtl/multiplier_iterative_param.sv
// Multi-cycle multiplier: adds DIGIT multiplier bits per clock, with signed or unsigned operands.
// Define MULT_ITER_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier_iterative_param #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multiplier_iterative_param_if.slave  bus
);
    localparam int ITER = WIDTH / DIGIT;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Operands are stored as magnitudes. The sign is applied once, at completion.
    typedef struct packed {
        logic [WIDTH-1:0] mp;
        logic [PW-1:0]    mc;
        logic [PW-1:0]    acc;
        logic [CW-1:0]    cnt;
        logic             neg;
    } op_t;

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    logic             ready_q, ready_d;
    logic             vout_q, vout_d;
    logic [PW-1:0]    r_q, r_d;

    logic             accept;
    logic             last_iter;
    logic             mp_zero;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] mp_nxt;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_nxt;

    assign accept = bus.valid_in & ready_q;

    always_comb begin
        mag_a     = (bus.signed_in & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b     = (bus.signed_in & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        partial   = PW'(op_q.mp[DIGIT-1:0]) * op_q.mc;
        acc_nxt   = op_q.acc + partial;
        mp_nxt    = op_q.mp >> DIGIT;
        last_iter = (op_q.cnt == CW'(ITER - 1));
`ifdef MULT_ITER_EARLY_TERM_EN
        mp_zero   = (mp_nxt == '0);
`else
        mp_zero   = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ready_d = ready_q;
        vout_d  = 1'b0;
        r_d     = r_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d    = RUN;
                    ready_d    = 1'b0;
                    op_d.mp    = mag_a;
                    op_d.mc    = PW'(mag_b);
                    op_d.acc   = '0;
                    op_d.cnt   = '0;
                    op_d.neg   = bus.signed_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                end else begin
                    state_d    = IDLE;
                    ready_d    = 1'b1;
                end
            end
            RUN: begin
                op_d.acc = acc_nxt;
                op_d.mp  = mp_nxt;
                op_d.mc  = op_q.mc << DIGIT;
                op_d.cnt = op_q.cnt + CW'(1);
                if (mp_zero || last_iter) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    vout_d  = 1'b1;
                    // A zero product with neg set still yields zero because -0 == 0.
                    r_d     = op_q.neg ? -acc_nxt : acc_nxt;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            ready_q <= 1'b1;
            vout_q  <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            vout_q  <= vout_d;
            r_q     <= r_d;
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.valid_out = vout_q;
    assign bus.r         = r_q;

endmodule
